// File: rtl/rr_event_encoder_pkg.sv
// ==== rr_event_encoder_pkg: shared sizes, FSM encoding and helpers. Rev 1.0 ====
`default_nettype none

package rr_event_encoder_pkg;
  localparam int N    = 16;
  localparam int IDXW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/rr_event_encoder_if.sv
// ==== rr_event_encoder_if: request capture + granted-index stream bundle. Rev 1.0 ====
`default_nettype none

interface rr_event_encoder_if;
  import rr_event_encoder_pkg::*;

  logic [N-1:0]    req;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    pending;
  logic            overflow;

  modport master (
    input  req,
    input  out_ready,
    output out_valid,
    output out_idx,
    output pending,
    output overflow
  );

  modport slave (
    output req,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  pending,
    input  overflow
  );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ==== rr_pick: round-robin selector (rotate by ptr, priority-encode, add ptr back). Rev 1.0 ====
`default_nettype none

module rr_pick
  import rr_event_encoder_pkg::*;
(
  input  logic [N-1:0]    pending,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] sel,
  output logic            any
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;

  // Index arithmetic is IDXW bits wide, so i+ptr wraps mod N for free.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = pending[IDXW'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDXW'(i);
      end
    end
  end

  assign sel = off + ptr;
  assign any = |pending;

endmodule

`default_nettype wire

// File: rtl/rr_event_encoder.sv
// ==== rr_event_encoder: captures event pulses, grants them round-robin as binary indices. Rev 1.0 ====
`default_nettype none

module rr_event_encoder
  import rr_event_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rr_event_encoder_if.master bus
);

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] idx_q, idx_nxt;
  logic [N-1:0]    pend_q, pend_nxt;
  logic [N-1:0]    grant_clr;
  logic            ovf_q, ovf_nxt;
  logic [IDXW-1:0] sel;
  logic            any;
  logic            load;

  rr_pick u_pick (
    .pending (pend_q),
    .ptr     (ptr),
    .sel     (sel),
    .any     (any)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (any) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase

    // The granted bit clears on load; a fresh req on the same edge re-arms it.
    grant_clr = load ? onehot(sel) : '0;
    pend_nxt  = (pend_q & ~grant_clr) | bus.req;
    ovf_nxt   = |(bus.req & pend_q & ~grant_clr);
    idx_nxt   = load ? sel : idx_q;
    ptr_nxt   = load ? sel + IDXW'(1) : ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      idx_q  <= idx_nxt;
      pend_q <= pend_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_idx   = idx_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_event_encoder.sv
// ==== tb_rr_event_encoder: vector table + scoreboard bench for rr_event_encoder. Rev 1.0 ====
`default_nettype none

module tb_rr_event_encoder;
  import rr_event_encoder_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  rr_event_encoder_if bus ();

  rr_event_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_q[$];
  logic [3:0] e;

  typedef struct {
    logic [15:0] req;
    int          cnt;
    logic [63:0] seq;
  } vec_t;

  vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Scoreboard: decoded one-hot of each transferred index against the expected one.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL grant: unexpected index %0d, none expected at %0t", bus.out_idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant", 32'(16'h1 << bus.out_idx), 32'(16'h1 << e));
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.out_ready = 1'b0;

    vec[0] = '{16'h0008, 1,  64'h3};
    vec[1] = '{16'h0021, 2,  64'h50};
    vec[2] = '{16'h8001, 2,  64'hF0};
    vec[3] = '{16'h1240, 3,  64'hC96};
    vec[4] = '{16'hFFFF, 16, 64'hFEDCBA9876543210};

    // Reset values hold even with requests asserted.
    #1;
    bus.req = 16'hFFFF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_idx", 32'(bus.out_idx), 0);
      chk("rst_pend", 32'(bus.pending), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      tick(1);
    end
    bus.req = '0;
    rst_n = 1'b1;
    tick(1);

    // Single event latency: valid two edges after the request is sampled.
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'h0008;
    exp_q.push_back(4'd3);
    tick(1);
    bus.req = '0;
    chk("lat_valid_e1", 32'(bus.out_valid), 0);
    tick(1);
    chk("lat_valid_e2", 32'(bus.out_valid), 1);
    chk("lat_idx_e2", 32'(bus.out_idx), 3);
    chk("lat_pend_e2", 32'(bus.pending), 0);
    tick(1);
    chk("lat_done", 32'(exp_q.size()), 0);

    // Vector table: burst of events, full-rate drain from ptr=0.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      bus.out_ready = 1'b1;
      bus.req = vec[t].req;
      for (int k = 0; k < vec[t].cnt; k++) exp_q.push_back(vec[t].seq[4*k +: 4]);
      tick(1);
      bus.req = '0;
      tick(vec[t].cnt + 1);
      chk("vec_drain", 32'(exp_q.size()), 0);
      chk("vec_valid", 32'(bus.out_valid), 0);
      chk("vec_pend", 32'(bus.pending), 0);
    end

    // Backpressure: index 0 held stable, then 0 and 5 delivered.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 16'h0021;
    tick(1);
    bus.req = '0;
    tick(1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_idx", 32'(bus.out_idx), 0);
      chk("bp_pend", 32'(bus.pending), 32'h20);
      tick(1);
    end
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd5);
    bus.out_ready = 1'b1;
    tick(3);
    chk("bp_drain", 32'(exp_q.size()), 0);
    chk("bp_idle", 32'(bus.out_valid), 0);

    // Re-request on the very edge its pending bit is cleared: kept, no overflow.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 16'h0008;
    tick(1);
    tick(1);
    bus.req = '0;
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_pend", 32'(bus.pending), 32'h8);
    chk("clr_idx", 32'(bus.out_idx), 3);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    bus.out_ready = 1'b1;
    tick(3);
    chk("clr_drain", 32'(exp_q.size()), 0);

    // Overflow and pointer wrap.
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'h4000;
    exp_q.push_back(4'd14);
    tick(1);
    bus.req = '0;
    tick(2);
    bus.out_ready = 1'b0;
    bus.req = 16'h8000;
    tick(1);
    bus.req = 16'h0004;
    tick(1);
    exp_q.push_back(4'd15);
    chk("ov_idx15", 32'(bus.out_idx), 15);
    chk("ov_pend_a", 32'(bus.pending), 32'h4);
    chk("ov_pre", 32'(bus.overflow), 0);
    bus.req = 16'h0004;
    tick(1);
    bus.req = '0;
    chk("ov_pulse", 32'(bus.overflow), 1);
    chk("ov_pend_b", 32'(bus.pending), 32'h4);
    tick(1);
    chk("ov_end", 32'(bus.overflow), 0);
    exp_q.push_back(4'd2);
    bus.out_ready = 1'b1;
    tick(2);
    chk("ov_drain", 32'(exp_q.size()), 0);
    chk("ov_pend_c", 32'(bus.pending), 0);
    tick(2);
    chk("ov_idle", 32'(bus.out_valid), 0);

    // Async reset mid-burst: outputs clear between edges.
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'hFFFF;
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    tick(1);
    bus.req = '0;
    tick(4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 0);
    chk("ar_idx", 32'(bus.out_idx), 0);
    chk("ar_pend", 32'(bus.pending), 0);
    chk("ar_ovf", 32'(bus.overflow), 0);
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    bus.req = 16'h8000;
    exp_q.push_back(4'd15);
    tick(1);
    bus.req = '0;
    tick(1);
    chk("ar_idx15", 32'(bus.out_idx), 15);
    tick(1);
    chk("ar_drain", 32'(exp_q.size()), 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
